// File: rtl/oam_dma.sv
// OAM DMA engine: FF46-triggered 160-byte copy into OAM,
// with CPU bus arbitration and an optional internal HRAM.
module oam_dma #(
  parameter int HRAM_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        phi,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic [15:0] mem_a,
  output logic [7:0]  mem_dout,
  input  logic [7:0]  mem_din,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  oam_a,
  output logic [7:0]  oam_dout,
  output logic        oam_we,
  output logic        dma_active
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    START,
    XFER
  } state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [1:0]  s;
  logic        phi_q;
  logic        wr_q;
  logic [7:0]  src_hi;
  logic [7:0]  idx;
  logic [7:0]  data_buf;
  logic [7:0]  eff_hi;
  logic        ff46_sel;
  logic        hram_sel;
  logic        detect;
  logic        mcyc_end;
  logic        xfer;
  logic [7:0]  hram [0:127];

  // Slot realigns to 0 on every rising CPU phase.
  assign s        = (phi && !phi_q) ? 2'd0 : cnt;
  assign mcyc_end = (s == 2'd3);
  assign xfer     = (state == XFER);
  assign ff46_sel = (cpu_a == 16'hFF46);
  assign hram_sel = (HRAM_EN != 0) && (cpu_a >= 16'hFF80)
                    && (cpu_a != 16'hFFFF);
  assign detect   = cpu_wr && !wr_q && ff46_sel;
  assign eff_hi   = (src_hi >= 8'hE0) ? (src_hi - 8'h20) : src_hi;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      phi_q      <= 1'b0;
      wr_q       <= 1'b0;
      src_hi     <= 8'hFF;
      idx        <= 8'd0;
      data_buf   <= 8'd0;
      oam_we     <= 1'b0;
      oam_a      <= 8'd0;
      oam_dout   <= 8'd0;
      dma_active <= 1'b0;
    end else begin
      phi_q  <= phi;
      wr_q   <= cpu_wr;
      cnt    <= s + 2'd1;
      oam_we <= 1'b0;
      if (detect) begin
        src_hi <= cpu_dout;
        idx    <= 8'd0;
        state  <= ARM;
      end else begin
        unique case (state)
          IDLE: ;
          ARM: begin
            if (mcyc_end) state <= START;
          end
          START: begin
            if (mcyc_end) begin
              state      <= XFER;
              dma_active <= 1'b1;
            end
          end
          XFER: begin
            if (s == 2'd1) data_buf <= mem_din;
            // Registered so the pulse lands on the s=3 clock.
            if (s == 2'd2) begin
              oam_we   <= 1'b1;
              oam_a    <= idx;
              oam_dout <= data_buf;
            end
            if (mcyc_end) begin
              if (idx == 8'd159) begin
                state      <= IDLE;
                dma_active <= 1'b0;
                idx        <= 8'd0;
              end else begin
                idx <= idx + 8'd1;
              end
            end
          end
        endcase
      end
    end
  end

  // HRAM survives reset; written on the rising CPU write strobe.
  always_ff @(posedge clk) begin
    if (hram_sel && cpu_wr && !wr_q)
      hram[cpu_a[6:0]] <= cpu_dout;
  end

  always_comb begin
    mem_a    = cpu_a;
    mem_dout = cpu_dout;
    mem_rd   = cpu_rd && !hram_sel;
    mem_wr   = cpu_wr && !hram_sel;
    if (xfer) begin
      mem_a  = {eff_hi, idx};
      mem_rd = (s != 2'd3);
      mem_wr = 1'b0;
    end
  end

  always_comb begin
    cpu_din = mem_din;
    if (ff46_sel)
      cpu_din = src_hi;
    else if (hram_sel)
      cpu_din = hram[cpu_a[6:0]];
    else if (xfer)
      cpu_din = 8'hFF;
  end

endmodule
